// File: rtl/clock_pkg.sv
// Shared widths, BCD limits and BCD helper functions for the time-of-day counter.
package clock_pkg;

  localparam int DIGIT_W = 4;
  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 8'h59;

  // Both nibbles are decimal digits and the packed value does not exceed max.
  // Packed BCD compares like the decimal number it encodes, so a plain
  // magnitude compare also enforces the tens limit (e.g. tens <= 5 for 59).
  function automatic logic bcd_valid(input logic [FIELD_W-1:0] v,
                                     input logic [FIELD_W-1:0] max);
    return (v[DIGIT_W-1:0] <= 4'd9) && (v[FIELD_W-1:DIGIT_W] <= 4'd9) && (v <= max);
  endfunction

  // Increment a packed BCD field, returning to 00 after max.
  function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    logic [FIELD_W-1:0] r;
    if (v == max)
      r = '0;
    else if (v[DIGIT_W-1:0] == 4'd9)
      r = {v[FIELD_W-1:DIGIT_W] + 4'd1, 4'd0};
    else
      r = {v[FIELD_W-1:DIGIT_W], v[DIGIT_W-1:0] + 4'd1};
    return r;
  endfunction

  // Convert a small decimal integer (0..99) to packed BCD.
  function automatic logic [FIELD_W-1:0] to_bcd(input int n);
    logic [FIELD_W-1:0] r;
    r[FIELD_W-1:DIGIT_W] = DIGIT_W'(n / 10);
    r[DIGIT_W-1:0]       = DIGIT_W'(n % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// One packed-BCD field counting 00..MAX; load has priority over increment.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX = 8'h59
) (
  input  logic               clk_100mhz,
  input  logic               rst_100mhz,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               wrap
);

  logic [FIELD_W-1:0] value_q, value_d;

  // Next value: load wins, otherwise step with wrap at MAX.
  always_comb begin
    value_d = value_q;
    if (load)
      value_d = load_val;
    else if (inc)
      value_d = bcd_inc(value_q, MAX);
  end

  // Field register.
  always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
    if (rst_100mhz)
      value_q <= '0;
    else
      value_q <= value_d;
  end

  assign value = value_q;
  // Combinational so the parent can chain carries within the same cycle.
  assign wrap  = inc && !load && (value_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// Wall-clock hh:mm:ss in packed BCD, advanced by 1 Hz tick rises, with
// full-time load and per-field adjust from the settings logic.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic               clk_100mhz,
  input  logic               rst_100mhz,
  input  logic               tick_1hz,
  input  logic               run,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_hh,
  input  logic [FIELD_W-1:0] load_mm,
  input  logic [FIELD_W-1:0] load_ss,
  input  logic               inc_hour,
  input  logic               inc_min,
  output logic [FIELD_W-1:0] hh,
  output logic [FIELD_W-1:0] mm,
  output logic [FIELD_W-1:0] ss,
  output logic               sec_pulse,
  output logic               min_carry,
  output logic               day_carry,
  output logic               load_err
);

  localparam logic [FIELD_W-1:0] HOUR_MAX_BCD = to_bcd(HOUR_MAX);

  logic tick_d_q;
  logic pending_q, pending_d;
  logic sec_pulse_q, sec_pulse_d;
  logic min_carry_q, min_carry_d;
  logic day_carry_q, day_carry_d;
  logic load_err_q, load_err_d;

  logic rise, load_ok, blocked, apply;
  logic adj_hour, adj_min;
  logic ss_inc, mm_inc, hh_inc;
  logic ss_wrap, mm_wrap, hh_wrap;

  // Every rise is parked in pending for one cycle, which gives the fixed
  // one-edge tick latency; a load/adjust cycle simply holds it there.
  always_comb begin
    rise     = tick_1hz & ~tick_d_q & run;
    load_ok  = load && bcd_valid(load_hh, HOUR_MAX_BCD)
                    && bcd_valid(load_mm, MIN_MAX)
                    && bcd_valid(load_ss, SEC_MAX);
    blocked  = load | inc_hour | inc_min;
    adj_hour = inc_hour & ~load;
    adj_min  = inc_min & ~load;
    apply    = pending_q & ~blocked;

    if (load_ok)
      pending_d = rise;
    else if (blocked)
      pending_d = pending_q | rise;
    else
      pending_d = rise;

    ss_inc = apply;
    mm_inc = adj_min | (apply & ss_wrap);
    hh_inc = adj_hour | (apply & ss_wrap & mm_wrap);

    sec_pulse_d = apply;
    min_carry_d = apply & ss_wrap;
    day_carry_d = apply & ss_wrap & mm_wrap & hh_wrap;
    load_err_d  = load & ~load_ok;
  end

  // Edge-detect flop, pending tick and registered pulse outputs.
  always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
    if (rst_100mhz) begin
      tick_d_q    <= 1'b0;
      pending_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      tick_d_q    <= tick_1hz;
      pending_q   <= pending_d;
      sec_pulse_q <= sec_pulse_d;
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
      load_err_q  <= load_err_d;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (ss_inc),
    .load       (load_ok),
    .load_val   (load_ss),
    .value      (ss),
    .wrap       (ss_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (mm_inc),
    .load       (load_ok),
    .load_val   (load_mm),
    .value      (mm),
    .wrap       (mm_wrap)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_hh (
    .clk_100mhz (clk_100mhz),
    .rst_100mhz (rst_100mhz),
    .inc        (hh_inc),
    .load       (load_ok),
    .load_val   (load_hh),
    .value      (hh),
    .wrap       (hh_wrap)
  );

  assign sec_pulse = sec_pulse_q;
  assign min_carry = min_carry_q;
  assign day_carry = day_carry_q;
  assign load_err  = load_err_q;

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Consumes the 1 Hz square wave produced by the 1 Hz generator stage and keeps wall-clock time as hours/minutes/seconds in packed BCD. It edge-detects the tick inside the 100 MHz domain and advances the counters with carry. It also accepts a full-time load and per-field increment pulses from the button/settings logic. Its outputs feed the display multiplexer and the alarm comparator.

## Interface
- HOUR_MAX, default 23: last hour value before wrap to 00; legal values are 11 and 23.
- clk_100mhz  in  1  system clock.
- rst_100mhz  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  1 Hz square wave, same clock domain; one rising edge per second.
- run  in  1  1 = count seconds; 0 = ticks ignored (time frozen).
- load  in  1  one-cycle strobe; load time from load_hh/load_mm/load_ss.
- load_hh, load_mm, load_ss  in  8 each  packed BCD load values.
- inc_hour, inc_min  in  1 each  one-cycle adjust strobes.
- hh, mm, ss  out  8 each  current time, packed BCD (tens in [7:4]).
- sec_pulse  out  1  one cycle high when ss advances due to a tick.
- min_carry  out  1  one cycle high when ss wraps 59 to 00 from a tick.
- day_carry  out  1  one cycle high on wrap HOUR_MAX:59:59 to 00:00:00.
- load_err  out  1  one cycle high when a load is rejected.

## Operation
- Edge detect: one flop tick_d. A rise is tick_1hz=1 while tick_d=0, and counts only when run=1.
- Priority per cycle: reset > load > inc_hour/inc_min > tick.
- Load validity checks:
  - every nibble ≤ 9;
  - minute and second tens ≤ 5;
  - hour ≤ HOUR_MAX.
- Valid load: write all three fields and clear any pending tick.
- Invalid load: no field changes, load_err=1 for one cycle, pending tick kept.
- Adjust:
  - inc_min: mm+1 mod 60, no carry into hh, ss unchanged.
  - inc_hour: hh+1 mod (HOUR_MAX+1).
  - Both high in one cycle: both apply independently.
- Tick collision: a rise in a cycle with load or adjust sets pending. Pending is applied on the next cycle with no load/adjust, then cleared. Only one tick can be pending; a second rise while pending is dropped. This cannot happen at 1 Hz.
- Tick advance:
  - ss+1.
  - At 59: ss=00, mm+1.
  - At mm 59: mm=00, hh+1.
  - At hh HOUR_MAX: hh=00.
  - BCD: units 9 wraps to 0 and increments tens.
- Carry flags for a tick advance are asserted in the same cycle the new value appears.
- Adjust and load never assert sec_pulse, min_carry or day_carry.

## Timing
- Reset values: hh=mm=ss=8'h00, tick_d=0, pending=0, all pulse outputs 0.
- Tick latency: tick_1hz first sampled high at edge N means ss updates at edge N+1. sec_pulse is high for the cycle after edge N+1.
- Deferred tick: applied one edge after the blocking load/adjust cycle ends.
- Load and adjust latency: fields update on the edge that samples the strobe. load_err is high in the following cycle.
- All outputs are registered; no combinational input-to-output path.
- Mid-operation reset: immediate asynchronous clear; the first rise after release counts normally.

## Structure
- Package clock_pkg holds:
  - BCD digit width (4) and field width (8);
  - SEC_MAX/MIN_MAX = 8'h59;
  - a function for BCD field validity;
  - a function for BCD increment mod N.
- Sub-module bcd_mod_counter, parameter MAX (packed BCD). It has ports inc, load, load_val, value and wrap (wrap pulses when inc occurs at MAX). It is instantiated three times; the top holds the edge detect, pending flag, priority logic and pulse registers.

## Test plan
- Reset, run=1, 61 tick rises → ss=8'h01, mm=8'h01; exactly one min_carry; 61 sec_pulse.
- Load 23:59:59, one rise → 00:00:00; sec_pulse, min_carry and day_carry all high in the same cycle.
- Load 8'h24/8'h00/8'h00 (HOUR_MAX=23), then 8'h12/8'h60/8'h00 → both rejected, load_err pulses, time unchanged; 8'h1A in ss also rejected.
- inc_min at mm=59, hh=05 → mm=00, hh=05, no carries. inc_hour at 23 → 00. Both together at 10:59 → 11:00.
- Tick rise in the same cycle as inc_min with ss=8'h30 → mm+1 that cycle; ss=8'h31 one cycle later with sec_pulse.
- run=0 for 5 rises → time constant. Reset asserted mid-count at 12:34:56 → all fields 00 immediately, pulses low.
